// File: rtl/usb_key_encoder.sv
// ASCII-to-HID keystroke encoder: a CPU-written character FIFO feeding a
// press / hold / release / gap report sequencer on a valid/ready stream.
module usb_key_encoder #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       R_W_n,
   input  logic [7:0] reg_addr_i,
   input  logic [7:0] data_i,
   input  logic       usb_cs,
   output logic [7:0] data_o,
   output logic       rpt_valid,
   input  logic       rpt_ready,
   output logic [7:0] rpt_mod,
   output logic [7:0] rpt_key
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned LW   = AW + 1;
   localparam int unsigned CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   localparam logic [7:0] MOD_NONE  = 8'h00;
   localparam logic [7:0] MOD_LCTRL = 8'h01;
   localparam logic [7:0] MOD_SHIFT = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS,
      S_HOLD,
      S_RELEASE,
      S_GAP
   } state_t;

   // Character to {mapped, modifier, key code}; control-code specials win over the ctrl range
   function automatic logic [16:0] lookup(input logic [7:0] c);
      logic [16:0] r;
      r = '0;
      if (c >= 8'h61 && c <= 8'h7A)      r = {1'b1, MOD_NONE,  c - 8'd93};
      else if (c >= 8'h41 && c <= 8'h5A) r = {1'b1, MOD_SHIFT, c - 8'd61};
      else if (c >= 8'h31 && c <= 8'h39) r = {1'b1, MOD_NONE,  c - 8'd19};
      else if (c == 8'h30)               r = {1'b1, MOD_NONE,  8'd39};
      else if (c == 8'h0D)               r = {1'b1, MOD_NONE,  8'd40};
      else if (c == 8'h1B)               r = {1'b1, MOD_NONE,  8'd41};
      else if (c == 8'h08)               r = {1'b1, MOD_NONE,  8'd42};
      else if (c == 8'h09)               r = {1'b1, MOD_NONE,  8'd43};
      else if (c == 8'h20)               r = {1'b1, MOD_NONE,  8'd44};
      else if (c >= 8'h01 && c <= 8'h1A) r = {1'b1, MOD_LCTRL, c + 8'd3};
      else begin
         case (c)
            8'h2D: r = {1'b1, MOD_NONE,  8'd45};  // -
            8'h3D: r = {1'b1, MOD_NONE,  8'd46};  // =
            8'h5B: r = {1'b1, MOD_NONE,  8'd47};  // [
            8'h5D: r = {1'b1, MOD_NONE,  8'd48};  // ]
            8'h5C: r = {1'b1, MOD_NONE,  8'd49};  // backslash
            8'h3B: r = {1'b1, MOD_NONE,  8'd51};  // ;
            8'h27: r = {1'b1, MOD_NONE,  8'd52};  // '
            8'h60: r = {1'b1, MOD_NONE,  8'd53};  // `
            8'h2C: r = {1'b1, MOD_NONE,  8'd54};  // ,
            8'h2E: r = {1'b1, MOD_NONE,  8'd55};  // .
            8'h2F: r = {1'b1, MOD_NONE,  8'd56};  // /
            8'h21: r = {1'b1, MOD_SHIFT, 8'd30};  // !
            8'h40: r = {1'b1, MOD_SHIFT, 8'd31};  // @
            8'h23: r = {1'b1, MOD_SHIFT, 8'd32};  // #
            8'h24: r = {1'b1, MOD_SHIFT, 8'd33};  // $
            8'h25: r = {1'b1, MOD_SHIFT, 8'd34};  // %
            8'h5E: r = {1'b1, MOD_SHIFT, 8'd35};  // ^
            8'h26: r = {1'b1, MOD_SHIFT, 8'd36};  // &
            8'h2A: r = {1'b1, MOD_SHIFT, 8'd37};  // *
            8'h28: r = {1'b1, MOD_SHIFT, 8'd38};  // (
            8'h29: r = {1'b1, MOD_SHIFT, 8'd39};  // )
            8'h5F: r = {1'b1, MOD_SHIFT, 8'd45};  // _
            8'h2B: r = {1'b1, MOD_SHIFT, 8'd46};  // +
            8'h7B: r = {1'b1, MOD_SHIFT, 8'd47};  // {
            8'h7D: r = {1'b1, MOD_SHIFT, 8'd48};  // }
            8'h7C: r = {1'b1, MOD_SHIFT, 8'd49};  // |
            8'h3A: r = {1'b1, MOD_SHIFT, 8'd51};  // :
            8'h22: r = {1'b1, MOD_SHIFT, 8'd52};  // "
            8'h7E: r = {1'b1, MOD_SHIFT, 8'd53};  // ~
            8'h3C: r = {1'b1, MOD_SHIFT, 8'd54};  // <
            8'h3E: r = {1'b1, MOD_SHIFT, 8'd55};  // >
            8'h3F: r = {1'b1, MOD_SHIFT, 8'd56};  // ?
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic          err_q, err_d;
   logic          empty, full, push, pop, bad_char, wr_en, clr_en;
   logic [16:0]   head_map;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_d;
   logic [7:0]    mod_d, key_d;

   // Register decode, FIFO occupancy and sticky error update
   always_comb begin
      wr_en    = usb_cs && !R_W_n && (reg_addr_i == 8'h00);
      clr_en   = usb_cs && !R_W_n && (reg_addr_i == 8'h01);
      empty    = (level_q == '0);
      full     = (level_q == LW'(FIFO_DEPTH));
      push     = wr_en && (!full || pop);
      head_map = lookup(mem[rd_ptr_q]);
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      err_d = (err_q && !clr_en) || (wr_en && !push) || bad_char;
   end

   // Combinational register read-back
   always_comb begin
      data_o = '0;
      case (reg_addr_i)
         8'h00:   data_o = {4'b0000, (state_q != S_IDLE), err_q, full, empty};
         8'h01:   data_o = 8'(level_q);
         default: data_o = '0;
      endcase
   end

   // Character storage; contents need no reset
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= data_i;
   end

   // FIFO pointers, level and error flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
         err_q   <= err_d;
      end
   end

   // Report sequencer next state and registered report outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      valid_d  = rpt_valid;
      mod_d    = rpt_mod;
      key_d    = rpt_key;
      pop      = 1'b0;
      bad_char = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (head_map[16]) begin
                  state_d = S_PRESS;
                  valid_d = 1'b1;
                  mod_d   = head_map[15:8];
                  key_d   = head_map[7:0];
               end else begin
                  bad_char = 1'b1;
               end
            end
         end
         S_PRESS: begin
            if (rpt_valid && rpt_ready) begin
               valid_d = 1'b0;
               cnt_d   = CW'(HOLD_CYCLES);
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_RELEASE;
               valid_d = 1'b1;
               mod_d   = '0;
               key_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RELEASE: begin
            if (rpt_valid && rpt_ready) begin
               valid_d = 1'b0;
               cnt_d   = CW'(GAP_CYCLES);
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            // Leaves one cycle early so the next pop lands GAP_CYCLES+1 after the release handshake
            if (cnt_q <= CW'(1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state, counter and report registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rpt_valid <= 1'b0;
         rpt_mod   <= '0;
         rpt_key   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rpt_valid <= valid_d;
         rpt_mod   <= mod_d;
         rpt_key   <= key_d;
      end
   end

endmodule
